uart_cmd_wrapper: RTL and testbench



---
 rtl/uart_cmd_wrapper_pkg.sv | 15 +
 rtl/uart_trcv.sv | 111 +++++++++++
 rtl/uart_cmd_wrapper.sv | 102 ++++++++++
 tb/tb_uart_cmd_wrapper.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_wrapper_pkg.sv
// rtl/uart_cmd_wrapper_pkg.sv - shared state type and constants for the UART command front end
package uart_cmd_wrapper_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } wrap_state_t;

  localparam int DEF_BAUD_DIV    = 434;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;

  localparam logic [7:0] COMM_COMPLETE     = 8'hA5;
  localparam logic [7:0] COMM_INTERMEDIATE = 8'h5A;

endpackage

// File: rtl/uart_trcv.sv
// rtl/uart_trcv.sv - full-duplex 8N1 byte transceiver (mid-bit sampling receiver, LSB-first transmitter)
module uart_trcv
  import uart_cmd_wrapper_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_busy,
  input  logic       clr_rx_rdy,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int             BW        = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  // first sample lands mid start bit once the synchroniser and edge-detect delay is included
  localparam logic [BW-1:0]  HALF_LOAD = BW'(BAUD_DIV / 2 - 2);

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic          r_rx_busy, r_rx_rdy;
  logic [BW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx_fall;

  logic          r_tx, r_tx_busy, r_tx_done;
  logic [BW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_rdy   <= 1'b0;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (clr_rx_rdy) r_rx_rdy <= 1'b0;
      if (!r_rx_busy) begin
        if (w_rx_fall) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= HALF_LOAD;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_baud != '0) begin
        r_rx_baud <= r_rx_baud - BW'(1);
      end else begin
        r_rx_baud <= BAUD_LAST;
        r_rx_bit  <= r_rx_bit + 4'd1;
        if (r_rx_bit >= 4'd1 && r_rx_bit <= 4'd8) r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        // stop-bit level is not checked: a framing error still delivers the byte
        if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_rdy  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else if (!r_tx_busy) begin
      if (trmt) begin
        r_tx       <= 1'b0;
        r_tx_busy  <= 1'b1;
        r_tx_done  <= 1'b0;
        r_tx_baud  <= BAUD_LAST;
        r_tx_bit   <= '0;
        r_tx_shift <= {1'b1, tx_data};
      end
    end else if (r_tx_baud != '0) begin
      r_tx_baud <= r_tx_baud - BW'(1);
    end else if (r_tx_bit == 4'd9) begin
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b1;
    end else begin
      r_tx       <= r_tx_shift[0];
      r_tx_shift <= {1'b1, r_tx_shift[8:1]};
      r_tx_bit   <= r_tx_bit + 4'd1;
      r_tx_baud  <= BAUD_LAST;
    end
  end

  assign TX      = r_tx;
  assign tx_done = r_tx_done;
  assign rx_rdy  = r_rx_rdy;
  assign rx_data = r_rx_shift;
  assign rx_busy = r_rx_busy;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - assembles two UART bytes into a 16-bit command and sends response bytes
// Optional high/low byte timeout enabled by defining UART_BYTE_TIMEOUT_EN.
module uart_cmd_wrapper
  import uart_cmd_wrapper_pkg::*;
#(
  parameter int BAUD_DIV    = DEF_BAUD_DIV,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  wrap_state_t r_state, w_next;
  logic [7:0]  r_high;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        w_rx_rdy, w_rx_busy, w_clr_rx_rdy;
  logic [7:0]  w_rx_data;
  logic        w_take_high, w_take_low, w_timeout;

  uart_trcv #(.BAUD_DIV(BAUD_DIV)) u_trcv (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (w_rx_rdy),
    .rx_data    (w_rx_data),
    .rx_busy    (w_rx_busy),
    .clr_rx_rdy (w_clr_rx_rdy),
    .trmt       (trmt),
    .tx_data    (resp),
    .tx_done    (tx_done)
  );

`ifdef UART_BYTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;

  // held at zero outside WAIT_LO so every entry starts a fresh window; frozen mid-byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_to_cnt <= '0;
    else if (r_state != WAIT_LO) r_to_cnt <= '0;
    else if (!w_rx_busy && !w_timeout) r_to_cnt <= r_to_cnt + TW'(1);
  end

  assign w_timeout = (r_state == WAIT_LO) && (r_to_cnt == TW'(TIMEOUT_CYC));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = w_rx_busy ^ (TIMEOUT_CYC > 0);
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_clr_rx_rdy = 1'b0;
    w_take_high  = 1'b0;
    w_take_low   = 1'b0;
    case (r_state)
      IDLE: if (w_rx_rdy) begin
        w_take_high  = 1'b1;
        w_clr_rx_rdy = 1'b1;
        w_next       = WAIT_LO;
      end
      WAIT_LO: if (w_rx_rdy) begin
        w_take_low   = 1'b1;
        w_clr_rx_rdy = 1'b1;
        w_next       = IDLE;
      end else if (w_timeout) begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_high    <= '0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take_high) r_high <= w_rx_data;
      if (w_take_low)  r_cmd  <= {r_high, w_rx_data};
      // a completing command beats a simultaneous acknowledge
      if (w_take_low)                        r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || w_take_high)   r_cmd_rdy <= 1'b0;
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - scoreboard bench for uart_cmd_wrapper (model follows UART_BYTE_TIMEOUT_EN)
module tb_uart_cmd_wrapper;
  import uart_cmd_wrapper_pkg::*;

  localparam int BD     = 20;
  localparam int TO     = 10000;
  localparam int RX_LAT = (19 * BD) / 2 + 3;
`ifdef UART_BYTE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst_n, RX, clr_cmd_rdy, trmt;
  logic [7:0]  resp;
  logic        TX, cmd_rdy, tx_done;
  logic [15:0] cmd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_trmt_cyc_q[$];
  bit          m_have_hi;
  logic [7:0]  m_hi;
  logic [15:0] m_last_cmd;
  int          byte_start_cyc;
  int          last_lat;

  uart_cmd_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void chk_rng(string name, int v, int lo, int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endfunction

  // byte-pairing model: a byte completes a command unless no high byte is pending or the gap timed it out
  function automatic void model_byte(logic [7:0] b, int idle);
    if (m_have_hi && !(TO_EN && idle > TO)) begin
      exp_cmd_q.push_back({m_hi, b});
      m_last_cmd = {m_hi, b};
      m_have_hi  = 1'b0;
    end else begin
      m_hi      = b;
      m_have_hi = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int idle);
    logic [9:0] f;
    model_byte(b, idle);
    repeat (idle) @(negedge clk);
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      if (i == 0) byte_start_cyc = cyc;
      repeat (BD) @(negedge clk);
    end
  endtask

  task automatic send_resp(input logic [7:0] r, input bit accept);
    resp = r;
    trmt = 1'b1;
    if (accept) begin
      exp_tx_q.push_back(r);
      exp_trmt_cyc_q.push_back(cyc);
    end
    @(negedge clk);
    trmt = 1'b0;
    if (accept) begin
      chk("TX start 1 clk after trmt", TX, 1'b0);
      chk("tx_done cleared by trmt", tx_done, 1'b0);
    end
  endtask

  task automatic wait_tx_done();
    for (int n = 0; n < 15 * BD && tx_done !== 1'b1; n++) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("cmd_rdy after clr", cmd_rdy, 1'b0);
    chk("cmd holds after clr", cmd, m_last_cmd);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_have_hi = 1'b0;
    @(negedge clk);
    chk({tag, " TX"}, TX, 1'b1);
    chk({tag, " cmd"}, cmd, 16'h0000);
    chk({tag, " cmd_rdy"}, cmd_rdy, 1'b0);
    chk({tag, " tx_done"}, tx_done, 1'b0);
    m_last_cmd = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : cmd_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (cmd_rdy === 1'b1 && !prev) begin
          last_lat = cyc - byte_start_cyc;
          chk_rng("cmd_rdy latency from low start", last_lat, RX_LAT - 1, RX_LAT + 1);
          if (exp_cmd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected cmd_rdy: got cmd %h expected no command", cmd);
          end else begin
            chk("cmd value", cmd, exp_cmd_q.pop_front());
          end
        end
        prev = (cmd_rdy === 1'b1);
      end
    end
  end

  initial begin : tx_mon
    logic [9:0] got;
    logic [7:0] e;
    int         fall_cyc;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        fall_cyc = cyc;
        if (exp_tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected TX frame: got start at cycle %0d expected idle", fall_cyc);
          repeat (11 * BD) @(negedge clk);
        end else begin
          e = exp_tx_q.pop_front();
          chk("TX fall latency", fall_cyc - exp_trmt_cyc_q.pop_front(), 1);
          for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? BD / 2 : BD) @(negedge clk);
            got[i] = TX;
          end
          chk("TX frame bits", got, {1'b1, e, 1'b0});
          for (int n = 0; n < 2 * BD && tx_done !== 1'b1; n++) @(negedge clk);
          chk("tx_done latency", cyc - fall_cyc, 10 * BD);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish before 80000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b1, b2;
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; trmt = 1'b0; resp = 8'h00;
    m_have_hi = 1'b0; m_hi = 8'h00; m_last_cmd = 16'h0000;
    byte_start_cyc = 0; last_lat = RX_LAT;
    repeat (3) @(negedge clk);
    chk("reset TX", TX, 1'b1);
    chk("reset cmd", cmd, 16'h0000);
    chk("reset cmd_rdy", cmd_rdy, 1'b0);
    chk("reset tx_done", tx_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    repeat (4) @(negedge clk);
    chk("cmd_rdy after 2000", cmd_rdy, 1'b1);
    pulse_clr();

    send_byte(8'h43, 0);
    send_byte(8'hF2, 0);
    fork
      send_byte(8'hC1, 0);
      begin
        repeat (RX_LAT - 3) @(negedge clk);
        chk("stale cmd_rdy before new high", cmd_rdy, 1'b1);
        repeat (5) @(negedge clk);
        chk("stale cmd_rdy dropped on new high", cmd_rdy, 1'b0);
      end
    join
    send_byte(8'h55, 0);
    repeat (4) @(negedge clk);

    send_byte(8'h9E, 3);
    fork
      send_byte(8'h3C, 0);
      begin
        repeat (last_lat - 1) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("set beats same-cycle clr", cmd_rdy, 1'b1);
        @(negedge clk);
        chk("cmd_rdy stays after collision", cmd_rdy, 1'b1);
      end
    join

    send_resp(COMM_COMPLETE, 1'b1);
    repeat (4 * BD) @(negedge clk);
    send_resp(COMM_INTERMEDIATE, 1'b0);
    wait_tx_done();
    repeat (3 * BD) @(negedge clk);
    chk("TX idle after frame", TX, 1'b1);
    chk("tx_done sticky", tx_done, 1'b1);

    send_byte(8'h20, 0);
    repeat (5) @(negedge clk);
    do_reset("mid-cmd reset");
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    repeat (4) @(negedge clk);

    send_byte(8'h20, 0);
    send_byte(8'h56, 12000);
    send_byte(8'h78, 0);
    repeat (10) @(negedge clk);
    do_reset("pre-random reset");

    for (int k = 0; k < 10; k++) begin
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      send_byte(b1, $urandom_range(0, 30));
      send_byte(b2, $urandom_range(0, 30));
      repeat (3) @(negedge clk);
      if ($urandom_range(0, 1) == 1) pulse_clr();
    end

    for (int k = 0; k < 3; k++) begin
      send_resp(8'($urandom), 1'b1);
      wait_tx_done();
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("cmd scoreboard drained", exp_cmd_q.size(), 0);
    chk("tx scoreboard drained", exp_tx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
